// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : Oversampling SPI slave with a single-entry tx holding buffer and
//            multi-word frame support; all four CPOL/CPHA modes.
// Revision : 1.0
// ============================================================================
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic                  csn_meta_q, csn_sync_q, csn_prev_q;
    logic                  mosi_meta_q, mosi_sync_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  buf_full_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  reload_q;
    logic                  skip_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  busy_q;
    logic                  frame_err_q;
    logic                  miso_q;

    logic                  sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic                  sample_edge, shift_edge, last_bit;
    logic [DATA_WIDTH-1:0] rx_word_d;
    logic [DATA_WIDTH-1:0] tx_next_word_d;

    // Synchronisers preset to the bus idle levels so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (srst) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            csn_meta_q  <= csn;
            csn_sync_q  <= csn_meta_q;
            csn_prev_q  <= csn_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise      = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall      = ~sclk_sync_q & sclk_prev_q;
    assign csn_fall       = ~csn_sync_q & csn_prev_q;
    assign csn_rise       = csn_sync_q & ~csn_prev_q;
    assign sample_edge    = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge     = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
    assign last_bit       = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign rx_word_d      = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q};
    assign tx_next_word_d = buf_full_q ? buf_data_q : TX_IDLE;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= S_IDLE;
            buf_data_q  <= '0;
            buf_full_q  <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            skip_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= busy_q ? tx_shift_q[DATA_WIDTH-1] : 1'b0;

            // Accept only while empty; unloads happen only while full, so the two never collide
            if (tx_valid && !buf_full_q) begin
                buf_data_q <= tx_data;
                buf_full_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (csn_fall) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    busy_q     <= 1'b1;
                    tx_shift_q <= tx_next_word_d;
                    if (buf_full_q) begin
                        buf_full_q <= 1'b0;
                    end
                    bit_cnt_q  <= '0;
                    reload_q   <= 1'b0;
                    skip_q     <= CPHA;
                    state_q    <= csn_rise ? S_IDLE : S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (sample_edge) begin
                        rx_shift_q <= rx_word_d;
                        if (last_bit) begin
                            bit_cnt_q  <= '0;
                            rx_data_q  <= rx_word_d;
                            rx_valid_q <= 1'b1;
                            reload_q   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    // With CPHA=1 the MSB is already on miso, so the first leading edge is a no-op
                    if (shift_edge) begin
                        if (reload_q) begin
                            tx_shift_q <= tx_next_word_d;
                            if (buf_full_q) begin
                                buf_full_q <= 1'b0;
                            end
                            reload_q <= 1'b0;
                        end else if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (csn_rise) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= '0;
                        reload_q    <= 1'b0;
                        frame_err_q <= sample_edge ? !last_bit : (bit_cnt_q != '0);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign miso      = miso_q;
    assign tx_ready  = ~buf_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Four spi_slave instances (one per SPI mode) driven by a bench SPI
//            master, checked against a word-level buffer/frame model.
// Revision : 1.0
// ============================================================================
module tb_spi_slave;

    localparam int         HALF    = 100;
    localparam logic [7:0] TX_IDLE = 8'h00;

    logic       clk;
    logic       srst;
    logic [3:0] sclk_r, csn_r, mosi_r, tx_valid_r;
    logic [7:0] tx_data_r [4];
    logic [3:0] miso_w, tx_ready_w, rx_valid_w, busy_w, ferr_w;
    logic [7:0] rx_data_w [4];

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         ferr_cnt [4];
    logic [9:0] act_rxq [$];
    logic [9:0] exp_rxq [$];
    logic       txm_full [4];
    logic [7:0] txm_data [4];
    logic [7:0] last_rx  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH(8),
            .CPOL      ((gi / 2) == 1),
            .CPHA      ((gi % 2) == 1),
            .TX_IDLE   (TX_IDLE)
        ) u_dut (
            .clk      (clk),
            .srst     (srst),
            .sclk     (sclk_r[gi]),
            .csn      (csn_r[gi]),
            .mosi     (mosi_r[gi]),
            .miso     (miso_w[gi]),
            .tx_data  (tx_data_r[gi]),
            .tx_valid (tx_valid_r[gi]),
            .tx_ready (tx_ready_w[gi]),
            .rx_data  (rx_data_w[gi]),
            .rx_valid (rx_valid_w[gi]),
            .busy     (busy_w[gi]),
            .frame_err(ferr_w[gi])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid_w[k]) act_rxq.push_back({2'(k), rx_data_w[k]});
            if (ferr_w[k]) ferr_cnt[k]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A word boundary takes the buffered word if there is one, else the idle word
    function automatic logic [7:0] pop_tx(input int m);
        if (txm_full[m]) begin
            txm_full[m] = 1'b0;
            return txm_data[m];
        end
        return TX_IDLE;
    endfunction

    task automatic push_tx(input int m, input logic [7:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        tx_data_r[m]  = d;
        tx_valid_r[m] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready_w[m]) begin
                @(posedge clk);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid_r[m] = 1'b0;
        if (done) begin
            txm_full[m] = 1'b1;
            txm_data[m] = d;
        end else begin
            chk("tx_handshake_timeout", 32'(0), 32'(1));
        end
    endtask

    task automatic reset_outputs_chk(input int m);
        chk("rst_miso",      32'(miso_w[m]),     32'(0));
        chk("rst_tx_ready",  32'(tx_ready_w[m]), 32'(1));
        chk("rst_rx_data",   32'(rx_data_w[m]),  32'(0));
        chk("rst_rx_valid",  32'(rx_valid_w[m]), 32'(0));
        chk("rst_busy",      32'(busy_w[m]),     32'(0));
        chk("rst_frame_err", 32'(ferr_w[m]),     32'(0));
    endtask

    // Bench SPI master: nw words from wrds (MSB word first); stop_after>0 ends the
    // frame after that many bits, either by raising csn or (do_rst) by asserting srst.
    task automatic spi_frame(input int m, input int nw, input logic [15:0] wrds,
                             input int stop_after, input bit do_rst);
        bit         cpha;
        bit         aborted;
        int         bits;
        logic [7:0] wd, got, exp_tx;
        cpha    = (m % 2) == 1;
        aborted = 1'b0;
        bits    = 0;
        got     = 8'h00;
        @(negedge clk);
        csn_r[m] = 1'b0;
        exp_tx   = pop_tx(m);
        #(HALF);
        for (int w = 0; w < nw && !aborted; w++) begin
            if (w > 0) exp_tx = pop_tx(m);
            wd = (w == 0) ? wrds[15:8] : wrds[7:0];
            for (int b = 7; b >= 0; b--) begin
                if (stop_after != 0 && bits == stop_after) begin
                    aborted = 1'b1;
                    break;
                end
                if (!cpha) begin
                    mosi_r[m] = wd[b];
                    #(HALF);
                    got[b]    = miso_w[m];
                    sclk_r[m] = ~sclk_r[m];
                    #(HALF);
                    sclk_r[m] = ~sclk_r[m];
                end else begin
                    sclk_r[m] = ~sclk_r[m];
                    mosi_r[m] = wd[b];
                    #(HALF);
                    got[b]    = miso_w[m];
                    sclk_r[m] = ~sclk_r[m];
                    #(HALF);
                end
                if (w == 0 && b == 7) chk("busy_in_frame", 32'(busy_w[m]), 32'(1));
                bits++;
            end
            if (!aborted) begin
                chk("miso_word", 32'(got), 32'(exp_tx));
                exp_rxq.push_back({2'(m), wd});
                last_rx[m] = wd;
            end
        end
        // CPHA=0: the trailing edge after the last sample is a shift edge, so one more reload happens
        if (!aborted && !cpha) void'(pop_tx(m));
        #(HALF);
        if (do_rst) begin
            @(negedge clk);
            srst = 1'b1;
            @(negedge clk);
            reset_outputs_chk(m);
            csn_r[m] = 1'b1;
            repeat (4) @(negedge clk);
            srst = 1'b0;
            for (int k = 0; k < 4; k++) begin
                txm_full[k] = 1'b0;
                last_rx[k]  = 8'h00;
            end
            exp_rxq.delete();
        end else begin
            csn_r[m] = 1'b1;
        end
        #(4 * HALF);
    endtask

    task automatic check_rx(input string tag);
        logic [9:0] e, a;
        chk({tag, "_rx_count"}, 32'(act_rxq.size()), 32'(exp_rxq.size()));
        while (exp_rxq.size() > 0) begin
            e = exp_rxq.pop_front();
            a = (act_rxq.size() > 0) ? act_rxq.pop_front() : 10'h3FF;
            chk({tag, "_rx_word"}, 32'(a), 32'(e));
        end
        act_rxq.delete();
    endtask

    initial begin
        int         fe;
        int         nw;
        logic [7:0] rnd;
        srst       = 1'b1;
        sclk_r     = 4'b1100;
        csn_r      = 4'b1111;
        mosi_r     = 4'b0000;
        tx_valid_r = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tx_data_r[k] = 8'h00;
            ferr_cnt[k]  = 0;
            txm_full[k]  = 1'b0;
            txm_data[k]  = 8'h00;
            last_rx[k]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) reset_outputs_chk(k);
        srst = 1'b0;
        repeat (5) @(negedge clk);

        // Mode 0 basic exchange
        push_tx(0, 8'h3C);
        chk("tx_ready_full", 32'(tx_ready_w[0]), 32'(0));
        spi_frame(0, 1, 16'hA500, 0, 1'b0);
        check_rx("m0_basic");
        chk("busy_after", 32'(busy_w[0]), 32'(0));
        chk("rx_data_hold", 32'(rx_data_w[0]), 32'(8'hA5));

        // Modes 1..3 two-word frames
        for (int m = 1; m < 4; m++) begin
            push_tx(m, 8'hC3);
            spi_frame(m, 2, 16'h817E, 0, 1'b0);
            check_rx("modes");
            chk("busy_after_mode", 32'(busy_w[m]), 32'(0));
        end

        // Underrun across a two-word frame
        push_tx(0, 8'h55);
        spi_frame(0, 2, 16'h1234, 0, 1'b0);
        check_rx("underrun");
        chk("tx_ready_after_load", 32'(tx_ready_w[0]), 32'(1));

        // Abort after 3 bits; the word taken at LOAD is lost
        push_tx(0, 8'h99);
        fe = ferr_cnt[0];
        spi_frame(0, 1, 16'hF000, 3, 1'b0);
        chk("abort_frame_err", 32'(ferr_cnt[0]), 32'(fe + 1));
        check_rx("abort");
        chk("abort_rx_data_kept", 32'(rx_data_w[0]), 32'(last_rx[0]));
        spi_frame(0, 1, 16'hF000, 0, 1'b0);
        check_rx("after_abort");
        chk("no_spurious_frame_err", 32'(ferr_cnt[0]), 32'(fe + 1));

        // Backpressure: second word waits for the next LOAD
        push_tx(0, 8'h11);
        @(negedge clk);
        tx_data_r[0]  = 8'h22;
        tx_valid_r[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_ready_low", 32'(tx_ready_w[0]), 32'(0));
        fork
            push_tx(0, 8'h22);
            spi_frame(0, 2, 16'hC44C, 0, 1'b0);
        join
        check_rx("backpressure");

        // Reset in the middle of a frame
        fe = ferr_cnt[0];
        spi_frame(0, 2, 16'hDEAD, 4, 1'b1);
        chk("rst_no_frame_err", 32'(ferr_cnt[0]), 32'(fe));
        check_rx("rst_partial");
        spi_frame(0, 1, 16'h9A00, 0, 1'b0);
        check_rx("after_rst");

        // Randomised frames in every mode
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) begin
                if (!txm_full[m] && ($urandom_range(0, 1) == 1)) begin
                    rnd = 8'($urandom);
                    push_tx(m, rnd);
                end
                nw = int'($urandom_range(1, 2));
                spi_frame(m, nw, 16'($urandom), 0, 1'b0);
                check_rx("random");
                chk("random_rx_data", 32'(rx_data_w[m]), 32'(last_rx[m]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint that sits on the far side of the bus from spi_master and consumes its sclk/csn/mosi while driving miso back.
- Oversamples the SPI pins in the system clock domain and deserialises mosi into DATA_WIDTH words, presented to local logic as a one-cycle rx_valid pulse.
- Serialises locally supplied tx words onto miso through a single-entry valid/ready holding buffer.
- Supports multi-word frames: csn held low across several words.

Parameters:
- DATA_WIDTH, 8, bits per word; MSB first on both lines.
- CPOL, 0, sclk idle level; must match the master.
- CPHA, 0, clock phase; must match the master.
- TX_IDLE, 0, word shifted out on miso when no tx word is buffered at a word boundary (underrun).

Ports:
- clk  input  1  system clock; frequency at least 8x the SPI clock.
- srst  input  1  synchronous reset, active-high.
- sclk  input  1  SPI clock from master, asynchronous to clk.
- csn  input  1  chip select, active-low, asynchronous.
- mosi  input  1  master-out data, asynchronous.
- miso  output  1  slave-out data.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding buffer empty; transfer occurs when tx_valid && tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while the synchronised csn is low.
- frame_err  output  1  one-cycle pulse when csn deasserts mid-word.

Behaviour:
- Reset (srst high at a clk edge) puts everything in its idle state, including a frame in progress:
  - Outputs: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0.
  - Internals: holding buffer empty, bit counter 0, state IDLE.
  - Synchronisers are preset to the idle levels (sclk=CPOL, csn=1).
- Synchronisation:
  - sclk, csn and mosi each pass through a 2-flop synchroniser.
  - A third flop on sclk and csn provides edge detection.
- Edge roles follow the same convention as the master:
  - CPOL^CPHA==0: sample on sclk rising, shift on sclk falling.
  - CPOL^CPHA==1: sample on sclk falling, shift on sclk rising.
- Sampling uses the synchronised mosi in the same cycle that the sample edge is detected.
- State machine:
  - IDLE -> LOAD: on detected csn falling edge.
  - LOAD (1 cycle): tx shift register loads the holding buffer if full (buffer marked empty, tx_ready=1 next cycle); otherwise loads TX_IDLE. Bit counter cleared. busy=1.
  - LOAD -> ACTIVE.
  - ACTIVE, each sample edge: rx shift register <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit counter +1.
  - ACTIVE, on the DATA_WIDTH-th sample: rx_data <= assembled word and rx_valid=1 in the following cycle; bit counter wraps to 0; the tx shift register reloads at the next shift edge (buffer, or TX_IDLE), so back-to-back words need no gap.
  - ACTIVE, each shift edge: tx shift register shifts left, zero fill.
  - CPHA=1 only: the first shift edge of each word performs no shift, because the MSB was preloaded.
  - ACTIVE -> IDLE on detected csn rising edge.
- Mid-word deassert: if the bit counter is nonzero when csn rises, pulse frame_err for 1 cycle. The partial word is discarded: no rx_valid, rx_data unchanged.
- Buffer state across frames: a tx word already moved into the shift register is lost on abort; a word still in the holding buffer is kept for the next frame.
- miso = tx_shift[DATA_WIDTH-1], registered, while busy; 0 when not busy.
- Latency:
  - Pin edge to internal edge detect: 3 clk.
  - Pin sample edge to rx_valid: 4 clk.
  - Pin shift edge to miso change: 4 clk. This is within a half SPI period at the 8x ratio.
- Simultaneous events:
  - A tx_valid handshake in the same cycle as the buffer unload: unload has priority; tx_ready is low that cycle, so no word is accepted or lost.
  - csn rising coincident with the final sample edge: the sample completes and rx_valid pulses; frame_err does not.
- tx_ready is never low longer than until the next word boundary or frame start.

Test Plan:
- Mode 0 with spi_master (50 MHz clk, 5 MHz SPI, DATA_WIDTH=8): slave tx_data=0x3C preloaded, master sends 0xA5 -> slave rx_data=0xA5 with exactly one rx_valid pulse; master data_recv=0x3C; busy high only while csn low.
- Modes 1, 2, 3 using a bench SPI BFM: send 0x81 and 0x7E with slave tx 0xC3 -> rx_data matches each word; BFM captures 0xC3 MSB-first in every mode.
- Underrun and multi-word: csn low for 16 sclk cycles, one tx word 0x55 buffered, TX_IDLE=0x00, mosi sends 0x12 then 0x34 -> rx_valid pulses twice (0x12, 0x34); miso carries 0x55 then 0x00; tx_ready returns high after LOAD.
- Abort: csn rises after 3 sclk cycles -> frame_err one-cycle pulse, no rx_valid, rx_data unchanged; next full frame receives 0xF0 correctly.
- Backpressure: tx_valid held with 0x11 then 0x22 while idle -> 0x11 accepted; tx_ready stays low until the next frame's LOAD, then 0x22 is accepted; the next two words on miso are 0x11 and 0x22.
- Reset mid-frame: assert srst after 4 bits -> all outputs at reset values the next cycle; after srst is released, a fresh frame receives 0x9A with a single rx_valid.
